// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter
//   Loopback monitor for a PWM waveform. Measures the high time and the
//   rising-to-rising period of pwm_in in clk cycles, then derives the duty
//   cycle in whole percent with a serial restoring divider (one quotient bit
//   per cycle). A line that shows no rising edge for 2^CNT_W-1 cycles is
//   flagged as stuck high or stuck low.
//
//   Optional build macro: PWM_DUTY_METER_GLITCH_FILTER_EN
//     When defined, a stability filter follows the synchronizer and pulses
//     shorter than FILTER_LEN cycles never reach the edge detector.
//
// Parameters
//   CNT_W        width of the high-time / period counters
//   SYNC_STAGES  synchronizer depth (values below 2 are treated as 2)
//   FILTER_LEN   glitch-filter stability length (filter builds only)
//
// Ports
//   clk         system clock, rising edge
//   reset       synchronous active-low reset
//   enable      measurement enable; low returns to IDLE and aborts a division
//   pwm_in      PWM waveform, asynchronous to clk
//   high_cnt    captured high time of the last complete period
//   period_cnt  captured rising-to-rising period
//   duty_pct    floor(high_cnt*100/period_cnt), 0..100
//   meas_valid  one-cycle pulse whenever the results update
//   busy        divider running
//   stuck_hi    timeout with the line high
//   stuck_lo    timeout with the line low
//
// Debug visibility: the FSM state lives in state_q (type state_t) so
// checkers can bind to it hierarchically.
module pwm_duty_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [6:0]       duty_pct,
    output logic             meas_valid,
    output logic             busy,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    // Dividend is high_cnt*100, which needs 7 extra bits.
    localparam int DW = CNT_W + 7;
    localparam int BW = $clog2(DW);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [BW-1:0]    BIT_LAST = BW'(DW - 1);
    localparam logic [DW-1:0]    HUNDRED  = DW'(100);
    localparam logic [6:0]       PCT_100  = 7'd100;
    localparam logic [6:0]       PCT_0    = 7'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2,
        S_DIV  = 2'd3
    } state_t;

    state_t state_q, state_d;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] sync_q;
    logic              lvl_sync;
    logic              lvl;
    logic              lvl_d;
    logic              rise;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_N-2:0], pwm_in};
        end
    end

    assign lvl_sync = sync_q[SYNC_N-1];

`ifdef PWM_DUTY_METER_GLITCH_FILTER_EN
    localparam int FLW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic           filt_q;
    logic [FLW-1:0] fcnt_q;

    // fcnt_q counts consecutive cycles in which the synchronized level
    // disagrees with the filtered level; the filtered level follows only
    // after FILTER_LEN such cycles in a row.
    always_ff @(posedge clk) begin
        if (!reset) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else if (lvl_sync == filt_q) begin
            fcnt_q <= '0;
        end else if (fcnt_q == FLW'(FILTER_LEN - 1)) begin
            filt_q <= lvl_sync;
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = lvl_sync;

    // FILTER_LEN only shapes the filter; this empty block keeps it
    // referenced in builds without the filter.
    if (FILTER_LEN < 1) begin : g_filter_len_unused
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            lvl_d <= 1'b0;
        end else begin
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic per_max;
    logic cap;
    logic timeout_hit;
    logic stuck_entry;
    logic div_last;

    logic [CNT_W-1:0] per_ctr;
    logic [CNT_W-1:0] hi_ctr;

    logic [BW-1:0] bit_q;

    assign per_max  = (per_ctr == CNT_MAX);
    assign cap      = enable && (state_q == S_RUN) && rise;
    // A rise always wins over the timeout: an edge proves the line is alive.
    assign timeout_hit = enable && !rise && per_max &&
                         ((state_q == S_RUN) || (state_q == S_ARM));
    // Counter stays saturated in ARM, so only a change of the flags is a
    // new entry into the stuck condition (one meas_valid per entry).
    assign stuck_entry = timeout_hit && ((stuck_hi != lvl) || (stuck_lo != ~lvl));
    assign div_last    = (state_q == S_DIV) && (bit_q == BIT_LAST);

    assign busy = (state_q == S_DIV);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (enable) state_d = S_ARM;
            S_ARM:  if (rise) state_d = S_RUN;
            S_RUN: begin
                if (rise) begin
                    state_d = S_DIV;
                end else if (per_max) begin
                    state_d = S_ARM;
                end
            end
            S_DIV:  if (div_last) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (!enable) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Period / high-time counters (saturating, reloaded to 1 on every rise)
    // ------------------------------------------------------------------
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            per_ctr <= '0;
            hi_ctr  <= '0;
        end else if (!enable || (state_q == S_IDLE)) begin
            per_ctr <= '0;
            hi_ctr  <= '0;
        end else if (rise) begin
            // The rise cycle itself is the first cycle of both the new
            // period and the new high phase.
            per_ctr <= CNT_ONE;
            hi_ctr  <= CNT_ONE;
        end else begin
            per_ctr <= sat_inc(per_ctr);
            if ((state_q != S_ARM) && lvl) begin
                hi_ctr <= sat_inc(hi_ctr);
            end
        end
    end

    // ------------------------------------------------------------------
    // Serial restoring divider: (high_cnt*100) / period_cnt
    // ------------------------------------------------------------------
    logic [DW-1:0]    dvd_q;
    logic [CNT_W-1:0] rem_q;
    logic [6:0]       quo_q;
    logic             div_done_q;

    logic [CNT_W:0]   trial;
    logic [CNT_W:0]   diff;
    logic             q_bit;
    logic [CNT_W-1:0] rem_nxt;

    // The remainder is always below the divisor, so CNT_W bits hold it and
    // the shifted trial value needs one extra bit.
    assign trial   = {rem_q, dvd_q[DW-1]};
    assign diff    = trial - {1'b0, period_cnt};
    assign q_bit   = (trial >= {1'b0, period_cnt});
    assign rem_nxt = q_bit ? diff[CNT_W-1:0] : trial[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            dvd_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            bit_q      <= '0;
            div_done_q <= 1'b0;
        end else begin
            // Result is published one cycle after the last quotient bit.
            div_done_q <= enable && div_last;
            if (cap) begin
                dvd_q <= {7'd0, hi_ctr} * HUNDRED;
                rem_q <= '0;
                quo_q <= '0;
                bit_q <= '0;
            end else if (state_q == S_DIV) begin
                dvd_q <= {dvd_q[DW-2:0], 1'b0};
                rem_q <= rem_nxt;
                // Quotient never exceeds 100, so only 7 bits are kept.
                quo_q <= {quo_q[5:0], q_bit};
                bit_q <= bit_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            high_cnt   <= '0;
            period_cnt <= '0;
            duty_pct   <= '0;
            meas_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else if (!enable) begin
            // Results hold; status and pulses drop.
            meas_valid <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if (cap) begin
                period_cnt <= per_ctr;
                high_cnt   <= hi_ctr;
            end
            if (div_done_q) begin
                duty_pct   <= quo_q;
                meas_valid <= 1'b1;
            end
            if (rise) begin
                stuck_hi <= 1'b0;
                stuck_lo <= 1'b0;
            end else if (stuck_entry) begin
                stuck_hi   <= lvl;
                stuck_lo   <= ~lvl;
                duty_pct   <= lvl ? PCT_100 : PCT_0;
                meas_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Testbench for pwm_duty_meter. Two instances share clock and stimulus:
// u_dut16 (CNT_W=16) covers latency, busy length, drop-during-DIV and
// enable abort; u_dut8 (CNT_W=8) reaches the stuck timeout quickly.
module tb_pwm_duty_meter;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic enable = 1'b0;
    logic pwm_in = 1'b0;

    logic [15:0] high16, period16;
    logic [6:0]  duty16;
    logic        mv16, busy16, shi16, slo16;

    logic [7:0]  high8, period8;
    logic [6:0]  duty8;
    logic        mv8, busy8, shi8, slo8;

    int n_checks = 0;
    int n_errors = 0;

    // PWM generator controls: mode 0 = const low, 1 = const high, 2 = pattern
    int gen_mode   = 0;
    int gen_high   = 0;
    int gen_period = 10;
    int gen_phase  = 0;
    int gen_spike  = -1;

    pwm_duty_meter #(.CNT_W(16), .SYNC_STAGES(2), .FILTER_LEN(3)) u_dut16 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .high_cnt   (high16),
        .period_cnt (period16),
        .duty_pct   (duty16),
        .meas_valid (mv16),
        .busy       (busy16),
        .stuck_hi   (shi16),
        .stuck_lo   (slo16)
    );

    pwm_duty_meter #(.CNT_W(8), .SYNC_STAGES(2), .FILTER_LEN(3)) u_dut8 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .pwm_in     (pwm_in),
        .high_cnt   (high8),
        .period_cnt (period8),
        .duty_pct   (duty8),
        .meas_valid (mv8),
        .busy       (busy8),
        .stuck_hi   (shi8),
        .stuck_lo   (slo8)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (gen_mode == 0) begin
                pwm_in = 1'b0;
            end else if (gen_mode == 1) begin
                pwm_in = 1'b1;
            end else begin
                pwm_in = (gen_phase < gen_high) || (gen_phase == gen_spike);
                gen_phase = (gen_phase + 1 >= gen_period) ? 0 : gen_phase + 1;
            end
        end
    end

    task automatic set_pattern(input int hi, input int per);
        gen_high   = hi;
        gen_period = per;
        gen_phase  = 0;
        gen_mode   = 2;
    endtask

    task automatic do_reset();
        reset  = 1'b0;
        enable = 1'b0;
        gen_mode  = 0;
        gen_spike = -1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_mv16(input int budget, output bit seen, output int waited);
        seen = 1'b0;
        waited = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            waited = k + 1;
            if (mv16) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_mv8(input int budget, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (mv8) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_busy16(input int budget, output bit seen, output int waited);
        seen = 1'b0;
        waited = 0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            waited = k + 1;
            if (busy16) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- stimulus + scoreboard ----------------
    initial begin
        bit seen;
        int waited;
        int busy_cnt;
        int lat;
        int pulses;

        // Reset state
        do_reset();
        check_val("rst_high16",   high16,   0);
        check_val("rst_period16", period16, 0);
        check_val("rst_duty16",   duty16,   0);
        check_val("rst_mv16",     mv16,     0);
        check_val("rst_busy16",   busy16,   0);
        check_val("rst_stuck16",  {shi16, slo16}, 0);
        check_val("rst_duty8",    duty8,    0);

        // 1: 5/10 -> 50 %, latency and busy length
        set_pattern(5, 10);
        enable = 1'b1;
        wait_busy16(100, seen, waited);
        check_val("t1_busy_seen", seen, 1);
        busy_cnt = 1;
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (busy16) busy_cnt++;
            if (mv16) begin
                lat = k;
                break;
            end
        end
        check_val("t1_latency",  lat,      24);
        check_val("t1_busy_len", busy_cnt, 23);
        check_val("t1_period",   period16, 10);
        check_val("t1_high",     high16,   5);
        check_val("t1_duty",     duty16,   50);
        @(negedge clk);
        check_val("t1_mv_one_cycle", mv16, 0);

        // 2: 3/10 -> 30, then 9/10 -> 90, edges during DIV dropped
        do_reset();
        set_pattern(3, 10);
        enable = 1'b1;
        wait_mv16(200, seen, waited);
        check_val("t2_mv30_seen", seen, 1);
        check_val("t2_duty30", duty16, 30);
        check_val("t2_high3",  high16, 3);
        set_pattern(9, 10);
        wait_mv16(100, seen, waited);
        check_val("t2_mvA_seen", seen, 1);
        wait_mv16(100, seen, waited);
        check_val("t2_mvB_seen", seen, 1);
        check_val("t2_duty90",  duty16,   90);
        check_val("t2_high9",   high16,   9);
        check_val("t2_period",  period16, 10);
        wait_mv16(100, seen, waited);
        check_val("t2_mvC_seen", seen, 1);
        check_val("t2_gap_dropped_edges", waited, 30);
        check_val("t2_duty90_again", duty16, 90);

        // 3: line held high, CNT_W=8 -> stuck_hi, 100 %, one pulse
        do_reset();
        gen_mode = 1;
        enable = 1'b1;
        pulses = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (mv8) pulses++;
        end
        check_val("t3_pulses",   pulses,  1);
        check_val("t3_stuck_hi", shi8,    1);
        check_val("t3_stuck_lo", slo8,    0);
        check_val("t3_duty100",  duty8,   100);
        check_val("t3_high_kept",   high8,   0);
        check_val("t3_period_kept", period8, 0);
        check_val("t3_no_stuck16",  shi16,   0);
        gen_mode = 0;
        repeat (4) @(negedge clk);
        gen_mode = 1;
        repeat (8) @(negedge clk);
        check_val("t3_rise_clears_hi", shi8, 0);
        check_val("t3_rise_clears_lo", slo8, 0);

        // 4: line held low -> stuck_lo, 0 %; then 2/7 -> 28 %
        do_reset();
        gen_mode = 0;
        enable = 1'b1;
        pulses = 0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (mv8) pulses++;
        end
        check_val("t4_pulses",   pulses, 1);
        check_val("t4_stuck_lo", slo8,   1);
        check_val("t4_stuck_hi", shi8,   0);
        check_val("t4_duty0",    duty8,  0);
        set_pattern(2, 7);
        wait_mv8(100, seen);
        check_val("t4_mv_seen",  seen,    1);
        check_val("t4_period7",  period8, 7);
        check_val("t4_high2",    high8,   2);
        check_val("t4_duty28",   duty8,   28);
        check_val("t4_lo_clear", slo8,    0);

        // 5: abort 5 cycles into DIV, hold outputs, re-enable arms first
        do_reset();
        set_pattern(5, 10);
        enable = 1'b1;
        wait_mv16(200, seen, waited);
        check_val("t5_first_mv", seen, 1);
        wait_busy16(60, seen, waited);
        check_val("t5_busy_seen", seen, 1);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_val("t5_busy_cleared", busy16, 0);
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mv16) pulses++;
        end
        check_val("t5_no_mv",      pulses,   0);
        check_val("t5_duty_hold",  duty16,   50);
        check_val("t5_high_hold",  high16,   5);
        check_val("t5_per_hold",   period16, 10);
        enable = 1'b1;
        wait_busy16(60, seen, waited);
        check_val("t5_rebusy_seen", seen, 1);
        check_val("t5_first_edge_arms", (waited >= 11) ? 1 : 0, 1);
        wait_mv16(60, seen, waited);
        check_val("t5_re_mv", seen, 1);
        check_val("t5_re_duty", duty16, 50);

        // 6: reset mid-RUN clears everything on the next edge
        do_reset();
        set_pattern(5, 10);
        enable = 1'b1;
        wait_mv16(200, seen, waited);
        check_val("t6_mv_seen", seen, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_val("t6_high0",   high16,   0);
        check_val("t6_period0", period16, 0);
        check_val("t6_duty0",   duty16,   0);
        check_val("t6_status0", {mv16, busy16, shi16, slo16}, 0);
        check_val("t6_duty8_0", duty8,    0);
        reset = 1'b1;

`ifdef PWM_DUTY_METER_GLITCH_FILTER_EN
        // 1-cycle spike inside the low phase must not disturb the result
        do_reset();
        gen_spike = 7;
        set_pattern(5, 10);
        enable = 1'b1;
        wait_mv16(200, seen, waited);
        check_val("glitch_mv_seen", seen, 1);
        check_val("glitch_period", period16, 10);
        check_val("glitch_high",   high16,   5);
        check_val("glitch_duty",   duty16,   50);
        gen_spike = -1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
